ysyx_22050243_pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It merges stall causes into per-stage pipeline-register write enables and bubble (flush) controls:
- ID-stage data hazards: jalr operand hazard and load-use.
- Multicycle MDU busy.
- Instruction-bus and data-bus wait.
- ID/EX redirects.

It also owns a small FSM that discards a fetch which is already in flight when a redirect happens.

---
 rtl/ysyx_22050243_pipe_ctrl.sv | 111 +++++++++++
 tb/tb_ysyx_22050243_pipe_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/ysyx_22050243_pipe_ctrl.sv
// ysyx_22050243_pipe_ctrl: pipeline stall/flush sequencer with in-flight fetch drop FSM.
// Optional perf counters enabled by defining YSYX_22050243_PIPE_PERF_CNT_EN.
module ysyx_22050243_pipe_ctrl #(
  parameter int DROP_W     = 1,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_jalr_i,
  input  logic                  stall_ld_use_i,
  input  logic                  redirect_id_i,
  input  logic                  redirect_ex_i,
  input  logic                  if_busy_i,
  input  logic                  if_valid_i,
  input  logic                  mdu_busy_i,
  input  logic                  mem_busy_i,
  output logic                  pc_we_o,
  output logic                  if_id_we_o,
  output logic                  id_ex_we_o,
  output logic                  ex_mem_we_o,
  output logic                  mem_wb_we_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
`ifdef YSYX_22050243_PIPE_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt_o,
`endif
  output logic                  drop_fetch_o
);
  typedef enum logic [DROP_W-1:0] {RUN = DROP_W'(0), DROP = DROP_W'(1)} state_e;
  state_e state_q, state_d;
  logic redir_apply;
  logic in_drop;
  assign in_drop = (state_q == DROP);
  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    id_ex_we_o     = 1'b1;
    ex_mem_we_o    = 1'b1;
    mem_wb_we_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    redir_apply    = 1'b0;
    if (mem_busy_i) begin
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
      mem_wb_we_o = 1'b0;
    end else if (mdu_busy_i) begin
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_we_o     = 1'b0;
      ex_mem_flush_o = 1'b1;
    end else if (redirect_ex_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      redir_apply   = 1'b1;
    end else if (stall_jalr_i || stall_ld_use_i) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (redirect_id_i) begin
      if_id_flush_o = 1'b1;
      redir_apply   = 1'b1;
    end else if (if_busy_i || (in_drop && !if_valid_i)) begin
      pc_we_o       = 1'b0;
      if_id_flush_o = 1'b1;
    end else begin
      if_id_flush_o = in_drop;
    end
    drop_fetch_o = in_drop;
    state_d = in_drop ? (if_valid_i ? RUN : DROP) : ((redir_apply && if_busy_i) ? DROP : RUN);
    // Reset forces a full bubble regardless of causes
    if (!rst_n) begin
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_we_o     = 1'b0;
      ex_mem_we_o    = 1'b0;
      mem_wb_we_o    = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      drop_fetch_o   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  end
`ifdef YSYX_22050243_PIPE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + (pc_we_o ? PERF_CNT_W'(0) : PERF_CNT_W'(1));
    flush_cnt_d = flush_cnt_q + (redir_apply ? PERF_CNT_W'(1) : PERF_CNT_W'(0));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_ysyx_22050243_pipe_ctrl.sv
// tb_ysyx_22050243_pipe_ctrl: directed scoreboard bench for the pipeline stall/flush sequencer.
module tb_ysyx_22050243_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_jalr_i = 0, stall_ld_use_i = 0, redirect_id_i = 0, redirect_ex_i = 0;
  logic if_busy_i = 0, if_valid_i = 0, mdu_busy_i = 0, mem_busy_i = 0;
  logic pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o;
  logic if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, drop_fetch_o;
`ifdef YSYX_22050243_PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif
  ysyx_22050243_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .stall_jalr_i(stall_jalr_i), .stall_ld_use_i(stall_ld_use_i),
    .redirect_id_i(redirect_id_i), .redirect_ex_i(redirect_ex_i),
    .if_busy_i(if_busy_i), .if_valid_i(if_valid_i),
    .mdu_busy_i(mdu_busy_i), .mem_busy_i(mem_busy_i),
    .pc_we_o(pc_we_o), .if_id_we_o(if_id_we_o), .id_ex_we_o(id_ex_we_o),
    .ex_mem_we_o(ex_mem_we_o), .mem_wb_we_o(mem_wb_we_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_flush_o(ex_mem_flush_o),
`ifdef YSYX_22050243_PIPE_PERF_CNT_EN
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .drop_fetch_o(drop_fetch_o)
  );
  always #5 clk = ~clk;
  localparam logic [7:0] J = 8'h80, L = 8'h40, RI = 8'h20, RE = 8'h10;
  localparam logic [7:0] B = 8'h08, V = 8'h04, M = 8'h02, X = 8'h01;
  // {pc, we if_id/id_ex/ex_mem/mem_wb, flush if_id/id_ex/ex_mem, drop}
  localparam logic [8:0] RESET = 9'b0_0000_111_0, NORM = 9'b1_1111_000_0;
  localparam logic [8:0] HAZ = 9'b0_0111_010_0, REDEX = 9'b1_1111_110_0;
  localparam logic [8:0] REDID = 9'b1_1111_100_0, IFWAIT = 9'b0_1111_100_0;
  localparam logic [8:0] FREEZE = 9'b0_0000_000_0, MDU = 9'b0_0011_001_0;
  localparam logic [8:0] DR = 9'b0_0000_000_1;
  typedef struct { logic [8:0] exp; string tag; } item_t;
  item_t q[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] in, input logic [8:0] exp, input string tag);
    @(negedge clk);
    rst_n = r;
    {stall_jalr_i, stall_ld_use_i, redirect_id_i, redirect_ex_i, if_busy_i, if_valid_i, mdu_busy_i, mem_busy_i} = in;
    q.push_back('{exp, tag});
  endtask
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk(it.tag, {23'd0, pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o,
                     if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, drop_fetch_o}, {23'd0, it.exp});
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, RESET, "reset");
    step(1, 0, NORM, "release");
    step(1, L, HAZ, "ld_use");
    step(1, J | RI, HAZ, "jalr_beats_redid");
    step(1, RE | RI | J, REDEX, "redex_beats_id");
    step(1, 0, NORM, "idle0");
    step(1, RI | B, REDID, "redid_busy");
    step(1, B, IFWAIT | DR, "drop_wait1");
    step(1, B, IFWAIT | DR, "drop_wait2");
    step(1, V, REDID | DR, "drop_valid");
    step(1, 0, NORM, "drop_done");
    step(1, RI | B, REDID, "redid_busy2");
    step(1, 0, IFWAIT | DR, "drop_novalid");
    step(1, RE, REDEX | DR, "redex_in_drop");
    step(1, RI | V, REDID | DR, "redid_valid_drop");
    step(1, 0, NORM, "no_second_drop");
    for (int i = 0; i < 4; i++) step(1, X | M | RE, FREEZE, "freeze");
    step(1, M | RE, MDU, "mdu_bubble");
    step(1, RE, REDEX, "redex_after_mdu");
    step(1, 0, NORM, "idle1");
    step(1, RI | B, REDID, "redid_busy3");
    step(1, B, IFWAIT | DR, "drop_wait3");
    step(0, B, RESET, "reset_mid_drop");
    step(1, 0, NORM, "after_reset");
`ifdef YSYX_22050243_PIPE_PERF_CNT_EN
    step(0, 0, RESET, "perf_reset");
    for (int i = 0; i < 5; i++) step(1, L, HAZ, "perf_stall");
    for (int i = 0; i < 2; i++) step(1, RE, REDEX, "perf_redir");
    @(negedge clk);
    #3;
    chk("perf_stall_cnt", perf_stall_cnt_o, 32'd5);
    chk("perf_flush_cnt", perf_flush_cnt_o, 32'd2);
    step(1, 0, NORM, "perf_idle");
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #5;
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
